// File: rtl/weight_pkg.sv
// Shared weight-RAM geometry and writer state encoding.
// Used by the RAM, the row readers and the write-side sequencer.
package weight_pkg;

  localparam int WEIGHT_W  = 10;
  localparam int N_WEIGHTS = 10;
  localparam int N_ROWS    = 10;
  localparam int ADDR_W    = 7;
  localparam int ROW_W     = 4;
  localparam int DEPTH     = N_ROWS * N_WEIGHTS;
  // One bit wider than the address so a limit of exactly 2**ADDR_W still fits.
  localparam int CNT_W     = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    WRITE = 2'd2
  } wr_state_t;

endpackage

// File: rtl/write_addr_gen.sv
// Loadable base + offset address counter for the weight RAM write port.
// On load the base is presented immediately and offset 1 is queued for the next cycle.
module write_addr_gen
  import weight_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  limit,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  limit_q, limit_d;

  // last means every word up to limit-1 has been issued; the offset saturates there.
  assign last = (off_q >= limit_q);
  assign addr = load ? base : (base_q + off_q[ADDR_W-1:0]);

  always_comb begin
    base_d  = base_q;
    off_d   = off_q;
    limit_d = limit_q;
    if (load) begin
      base_d  = base;
      off_d   = CNT_W'(1);
      limit_d = limit;
    end else if (en && !last) begin
      off_d = off_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      off_q   <= '0;
      limit_q <= '0;
    end else begin
      base_q  <= base_d;
      off_q   <= off_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/weight_ram_writer.sv
// Write-side sequencer for the weight RAM: LFSR power-up fill or single-row write,
// one registered word per clock on the RAM write port.
module weight_ram_writer
  import weight_pkg::*;
(
  input  logic                          Clock,
  input  logic                          Rst,
  input  logic                          init_start,
  input  logic [WEIGHT_W-1:0]           rnd_data,
  input  logic                          row_valid,
  output logic                          row_ready,
  input  logic [ROW_W-1:0]              row_index,
  input  logic [N_WEIGHTS*WEIGHT_W-1:0] row_data,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [WEIGHT_W-1:0]           ram_data,
  output logic                          busy,
  output logic                          init_done,
  output logic                          row_err
);

  if (DEPTH > 2**ADDR_W) begin : g_depth_chk
    $error("weight_ram_writer: DEPTH does not fit in ADDR_W");
  end
  if (N_ROWS > 2**ROW_W) begin : g_rows_chk
    $error("weight_ram_writer: N_ROWS does not fit in ROW_W");
  end

  wr_state_t                     state_q, state_d;
  logic                          we_q, we_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [WEIGHT_W-1:0]           data_q, data_d;
  logic [N_WEIGHTS*WEIGHT_W-1:0] row_q, row_d;
  logic                          init_done_q, init_done_d;
  logic                          err_q, err_d;

  logic              gen_load, gen_en, gen_last;
  logic [ADDR_W-1:0] gen_base, gen_addr;
  logic [CNT_W-1:0]  gen_limit;
  logic              row_ok;
  logic [ADDR_W-1:0] row_base;

  write_addr_gen u_addr_gen (
    .clk   (Clock),
    .rst   (Rst),
    .load  (gen_load),
    .en    (gen_en),
    .base  (gen_base),
    .limit (gen_limit),
    .addr  (gen_addr),
    .last  (gen_last)
  );

  assign row_ready = (state_q == IDLE) && !init_start;
  assign row_ok    = ({1'b0, row_index} < (ROW_W+1)'(N_ROWS));
  assign row_base  = ADDR_W'(row_index) * ADDR_W'(N_WEIGHTS);

  // The latched row is shifted down one weight per issued word, so the next
  // weight to write is always in the low slice.
  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    row_d       = row_q;
    init_done_d = init_done_q;
    err_d       = 1'b0;
    gen_load    = 1'b0;
    gen_en      = 1'b0;
    gen_base    = '0;
    gen_limit   = '0;
    unique case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d     = INIT;
          init_done_d = 1'b0;
          gen_load    = 1'b1;
          gen_limit   = CNT_W'(DEPTH);
          we_d        = 1'b1;
          addr_d      = gen_addr;
          data_d      = rnd_data;
        end else if (row_valid) begin
          if (row_ok) begin
            state_d   = WRITE;
            gen_load  = 1'b1;
            gen_base  = row_base;
            gen_limit = CNT_W'(N_WEIGHTS);
            we_d      = 1'b1;
            addr_d    = gen_addr;
            data_d    = row_data[WEIGHT_W-1:0];
            row_d     = row_data >> WEIGHT_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      INIT: begin
        if (gen_last) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          gen_en = 1'b1;
          we_d   = 1'b1;
          addr_d = gen_addr;
          data_d = rnd_data;
        end
      end
      WRITE: begin
        if (gen_last) begin
          state_d = IDLE;
        end else begin
          gen_en = 1'b1;
          we_d   = 1'b1;
          addr_d = gen_addr;
          data_d = row_q[WEIGHT_W-1:0];
          row_d  = row_q >> WEIGHT_W;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      row_q       <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      row_q       <= row_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
    end
  end

  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_data  = data_q;
  assign busy      = (state_q != IDLE);
  assign init_done = init_done_q;
  assign row_err   = err_q;

endmodule
